// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C SCL generator: FSM state encoding and the
// smallest half-period divisor the generator will run with.
package i2c_pkg;

   localparam int MIN_DIV = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOW       = 2'd1,
      HIGH_WAIT = 2'd2,
      HIGH      = 2'd3
   } sclState_t;

endpackage

// File: rtl/i2c_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset level so an idle open-drain bus reads as released.
module i2c_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL clock generator: open-drain SCL with clock-stretch detection and
// single-cycle strobes at each edge and mid-point of the low and high halves.
module i2c_scl_gen
   import i2c_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div,
   input  logic             scl_in,
   output logic             scl_oe,
   output logic             fall_stb,
   output logic             rise_stb,
   output logic             mid_low_stb,
   output logic             mid_high_stb,
   output logic             busy,
   output logic             stretching
);

   localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);

   sclState_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] effDiv_q, effDiv_d;
   logic [CNT_W-1:0] clampedDiv;
   logic [CNT_W-1:0] halfDiv;
   logic             sclSync;

   i2c_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (scl_in),
      .q_o   (sclSync)
   );

   // A minimum divisor of 2 keeps fall, mid and rise strobes on separate cycles.
   assign clampedDiv = (div < MIN_DIV_W) ? MIN_DIV_W : div;
   assign halfDiv    = effDiv_q >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         effDiv_q <= MIN_DIV_W;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         effDiv_q <= effDiv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      effDiv_d = effDiv_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d  = LOW;
               cnt_d    = '0;
               effDiv_d = clampedDiv;
            end
         end
         LOW: begin
            if (cnt_q == effDiv_q) begin
               state_d = HIGH_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // No timeout: a slave may stretch SCL low for as long as it likes.
         HIGH_WAIT: begin
            cnt_d = '0;
            if (sclSync) begin
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (cnt_q == effDiv_q) begin
               cnt_d = '0;
               if (en) begin
                  state_d  = LOW;
                  effDiv_d = clampedDiv;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode registered state only, so reset releases SCL without a clock.
   assign scl_oe       = (state_q == LOW);
   assign fall_stb     = (state_q == LOW) && (cnt_q == '0);
   assign mid_low_stb  = (state_q == LOW) && (cnt_q == halfDiv);
   assign rise_stb     = (state_q == HIGH_WAIT) && sclSync;
   assign stretching   = (state_q == HIGH_WAIT) && !sclSync;
   assign mid_high_stb = (state_q == HIGH) && (cnt_q == halfDiv);
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed self-checking bench for i2c_scl_gen: a table of divisor vectors
// measured over one full SCL period each, plus hand-written corner sequences.
module tb_i2c_scl_gen;

   localparam int CNT_W       = 16;
   localparam int SYNC_STAGES = 2;

   typedef struct {
      int divVal;
      int expLow;
      int expMidLow;
      int expHigh;
      int expMidHigh;
   } vector_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [CNT_W-1:0] div;
   logic             sclHoldLow;
   logic             sclIn;
   logic             sclOe;
   logic             fallStb;
   logic             riseStb;
   logic             midLowStb;
   logic             midHighStb;
   logic             busy;
   logic             stretching;

   int      checks = 0;
   int      errors = 0;
   vector_t vectors[7];

   always #5 clk = ~clk;

   // Open-drain bus model: SCL follows our own drive unless a slave holds it low.
   assign sclIn = sclHoldLow ? 1'b0 : !sclOe;

   i2c_scl_gen #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .div          (div),
      .scl_in       (sclIn),
      .scl_oe       (sclOe),
      .fall_stb     (fallStb),
      .rise_stb     (riseStb),
      .mid_low_stb  (midLowStb),
      .mid_high_stb (midHighStb),
      .busy         (busy),
      .stretching   (stretching)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Runs one SCL period from the next fall_stb and measures it at negedges.
   task automatic applyStimulus(input int vDiv, input bit dropEn, input int holdCycles,
                                input int divMidHigh,
                                output int lowLen, output int highLen,
                                output int midLowAt, output int midHighAt,
                                output int riseAt, output int stretchCnt,
                                output bit clash, output bit timedOut);
      int phase;
      int k;
      lowLen = 0; highLen = 0; midLowAt = -1; midHighAt = -1;
      riseAt = -1; stretchCnt = 0; clash = 1'b0; timedOut = 1'b1;
      phase = 0; k = 0;
      div = CNT_W'(vDiv);
      en  = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if ($countones({fallStb, riseStb, midLowStb, midHighStb}) > 1) clash = 1'b1;
         if (phase == 3) begin
            if (fallStb || !busy) begin
               timedOut = 1'b0;
               break;
            end
            if (midHighStb) begin
               midHighAt = highLen;
               if (divMidHigh >= 0) div = CNT_W'(divMidHigh);
            end
            highLen++;
         end else begin
            if (phase == 0 && fallStb) begin
               phase = 1;
               if (dropEn) en = 1'b0;
               sclHoldLow = (holdCycles > 0);
            end
            if (phase == 1 && !sclOe) begin
               phase = 2;
               k = 0;
            end
            if (phase == 1) begin
               if (midLowStb) midLowAt = lowLen;
               lowLen++;
            end else if (phase == 2) begin
               if (stretching) stretchCnt++;
               if (riseStb) begin
                  riseAt = k;
                  phase = 3;
               end
               if (holdCycles > 0 && k == holdCycles) sclHoldLow = 1'b0;
               k++;
            end
         end
      end
   endtask

   task automatic waitIdle(input string name);
      bit gotIdle;
      gotIdle = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!busy) begin
            gotIdle = 1'b1;
            break;
         end
      end
      checkOutput(name, gotIdle, 1);
   endtask

   initial begin
      int  lowLen, highLen, midLowAt, midHighAt, riseAt, stretchCnt;
      bit  clash, timedOut, sawFall, gotFall;
      int  n;

      vectors[0] = '{9, 10, 4, 10, 4};
      vectors[1] = '{0, 3, 1, 3, 1};
      vectors[2] = '{1, 3, 1, 3, 1};
      vectors[3] = '{2, 3, 1, 3, 1};
      vectors[4] = '{3, 4, 1, 4, 1};
      vectors[5] = '{4, 5, 2, 5, 2};
      vectors[6] = '{5, 6, 2, 6, 2};

      rst_n = 1'b0; en = 1'b0; div = CNT_W'(9); sclHoldLow = 1'b0;
      @(negedge clk);
      checkOutput("reset scl_oe", sclOe, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset stretching", stretching, 0);
      checkOutput("reset strobes", $countones({fallStb, riseStb, midLowStb, midHighStb}), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("idle without en", int'({busy, sclOe}), 0);
      end

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vectors[i].divVal, 1'b1, 0, -1, lowLen, highLen, midLowAt,
                       midHighAt, riseAt, stretchCnt, clash, timedOut);
         checkOutput($sformatf("v%0d timeout", i), timedOut, 0);
         checkOutput($sformatf("v%0d low len", i), lowLen, vectors[i].expLow);
         checkOutput($sformatf("v%0d mid low", i), midLowAt, vectors[i].expMidLow);
         checkOutput($sformatf("v%0d rise delay", i), riseAt, SYNC_STAGES);
         checkOutput($sformatf("v%0d stretch", i), stretchCnt, SYNC_STAGES);
         checkOutput($sformatf("v%0d high len", i), highLen, vectors[i].expHigh);
         checkOutput($sformatf("v%0d mid high", i), midHighAt, vectors[i].expMidHigh);
         checkOutput($sformatf("v%0d strobe clash", i), clash, 0);
         checkOutput($sformatf("v%0d idle oe", i), int'({busy, sclOe}), 0);
         repeat (2) @(negedge clk);
      end

      // en was dropped in LOW on the last vector: no new period may start.
      sawFall = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fallStb || busy) sawFall = 1'b1;
      end
      checkOutput("no fall after en drop", sawFall, 0);

      // Slave holds SCL low across the first 50 released cycles.
      applyStimulus(9, 1'b1, 50, -1, lowLen, highLen, midLowAt, midHighAt,
                    riseAt, stretchCnt, clash, timedOut);
      checkOutput("stretch timeout", timedOut, 0);
      checkOutput("stretch low len", lowLen, 10);
      checkOutput("stretch count", stretchCnt, 52);
      checkOutput("stretch rise delay", riseAt, 52);
      checkOutput("stretch high len", highLen, 10);
      checkOutput("stretch mid high", midHighAt, 4);
      repeat (2) @(negedge clk);

      // div changed 9 -> 3 at mid-high: current half unaffected, next low is 4.
      applyStimulus(9, 1'b0, 0, 3, lowLen, highLen, midLowAt, midHighAt,
                    riseAt, stretchCnt, clash, timedOut);
      checkOutput("divchg timeout", timedOut, 0);
      checkOutput("divchg high len", highLen, 10);
      checkOutput("divchg mid high", midHighAt, 4);
      checkOutput("divchg fall seen", fallStb, 1);
      en = 1'b0;
      n = 1;
      for (int i = 0; i < 50 && sclOe; i++) begin
         @(negedge clk);
         if (sclOe) n++;
      end
      checkOutput("divchg next low len", n, 4);
      waitIdle("divchg idle");

      // Asynchronous reset in the middle of a low half.
      div = CNT_W'(9); en = 1'b1;
      gotFall = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fallStb) begin
            gotFall = 1'b1;
            break;
         end
      end
      checkOutput("rst test fall", gotFall, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async rst scl_oe", sclOe, 0);
      checkOutput("async rst busy", busy, 0);
      checkOutput("async rst strobes",
                  $countones({fallStb, riseStb, midLowStb, midHighStb, stretching}), 0);
      @(negedge clk);
      checkOutput("held rst scl_oe", sclOe, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("restart fall", fallStb, 1);
      checkOutput("restart scl_oe", sclOe, 1);
      en = 1'b0;
      waitIdle("restart idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
